// File: rtl/multiplier_16_bit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_16_bit_seq
//  Description : Iterative unsigned 16x16->32 shift-add multiplier. Uses an
//                external 16-bit ripple adder via the Add_* ports and
//                registers its sum/carry each iteration. Busy is high while
//                iterating. Done pulses for one cycle when Product is valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_16_bit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Add_A,
    output logic [15:0] Add_B,
    output logic        Add_Cin,
    input  logic [15:0] Add_S,
    input  logic        Add_Cout,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic        Overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] C_LAST_ITER = 5'd15;

    logic [1:0]  state_q,    state_d;
    logic [15:0] m_q,        m_d;
    logic [15:0] p_hi_q,     p_hi_d;
    logic [15:0] p_lo_q,     p_lo_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic [31:0] product_q,  product_d;
    logic        overflow_q, overflow_d;

    // Adder operands come straight from the registers; the multiplicand is
    // only added in when the current low multiplier bit is set.
    assign Add_A   = p_hi_q;
    assign Add_B   = p_lo_q[0] ? m_q : 16'h0000;
    assign Add_Cin = 1'b0;

    assign Busy     = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign Product  = product_q;
    assign Overflow = overflow_q;

    // Next-state logic: load on Start, shift the {carry, sum, P_lo} window
    // right by one each RUN cycle, and latch the result on the last step.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        p_hi_d     = p_hi_q;
        p_lo_d     = p_lo_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    m_d     = A;
                    p_lo_d  = B;
                    p_hi_d  = 16'h0000;
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry-out becomes the new MSB so no product bit is lost.
                p_hi_d = {Add_Cout, Add_S[15:1]};
                p_lo_d = {Add_S[0], p_lo_q[15:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == C_LAST_ITER) begin
                    product_d  = {p_hi_d, p_lo_d};
                    overflow_d = |p_hi_d;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= 16'h0000;
            p_hi_q     <= 16'h0000;
            p_lo_q     <= 16'h0000;
            cnt_q      <= 5'd0;
            product_q  <= 32'h0000_0000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            p_hi_q     <= p_hi_d;
            p_lo_q     <= p_lo_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_16_bit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_16_bit_seq
//  Description : Self-checking bench for multiplier_16_bit_seq with a
//                behavioural 16-bit adder attached to the Add_* ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_16_bit_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        overflow;

    int n_cmp;
    int n_err;

    multiplier_16_bit_seq dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (start),
        .A        (a),
        .B        (b),
        .Add_A    (add_a),
        .Add_B    (add_b),
        .Add_Cin  (add_cin),
        .Add_S    (add_s),
        .Add_Cout (add_cout),
        .Busy     (busy),
        .Done     (done),
        .Product  (product),
        .Overflow (overflow)
    );

    // External ripple adder stand-in
    logic [16:0] w_sum;
    assign w_sum    = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};
    assign add_s    = w_sum[15:0];
    assign add_cout = w_sum[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_p;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives Start at the current negedge and follows one operation.
    // lat = posedges after the Start edge until Done is seen (expect 16),
    // occ = cycles spent with Busy or Done high (expect 17).
    task automatic run_mul(input logic [15:0] va, input logic [15:0] vb,
                           output logic [31:0] p, output logic ov,
                           output int lat, output int occ);
        int both;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        occ   = 0;
        both  = 0;
        while (!done && lat < 40) begin
            if (busy) occ++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) both++;
        if (done) occ++;
        p  = product;
        ov = overflow;
        @(negedge clk);
        if (busy || done) both++;
        chk("busy_done_exclusive_and_idle_after", both, 0);
    endtask

    logic [31:0] p;
    logic        ov;
    int          lat;
    int          occ;
    int          ndone;
    logic [31:0] exp_p;
    logic [15:0] ra;
    logic [15:0] rb;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
        vecs[2] = '{16'h0000, 16'h1234, 32'h00000000, 1'b0};
        vecs[3] = '{16'h1234, 16'h0001, 32'h00001234, 1'b0};
        vecs[4] = '{16'h0100, 16'h0100, 32'h00010000, 1'b1};
        vecs[5] = '{16'h8000, 16'h0002, 32'h00010000, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_product", product, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_add_a", {16'h0, add_a}, 32'h0);
        chk("rst_add_b", {16'h0, add_b}, 32'h0);
        chk("rst_add_cin", {31'h0, add_cin}, 32'h0);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_mul(vecs[i].a, vecs[i].b, p, ov, lat, occ);
            chk($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
            chk($sformatf("vec%0d_overflow", i), {31'h0, ov}, {31'h0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_latency", i), lat, 16);
            chk($sformatf("vec%0d_occupancy", i), occ, 17);
        end

        // Product holds through IDLE
        repeat (3) @(negedge clk);
        chk("hold_in_idle", product, 32'h0000FFFF);

        // Start re-pulsed mid-RUN must be ignored and not queued
        a     = 16'h0100;
        b     = 16'h0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_in_run", product, 32'h0000FFFF);
        a     = 16'h0007;
        b     = 16'h0007;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                ndone++;
                chk("midstart_product", product, 32'h00010000);
            end
            @(negedge clk);
        end
        chk("midstart_single_done", ndone, 1);
        chk("midstart_final", product, 32'h00010000);

        // Reset during RUN, with Start held alongside rst
        a     = 16'h0009;
        b     = 16'h0009;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_product", product, 32'h0);
        chk("midrst_overflow", {31'h0, overflow}, 32'h0);
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("midrst_no_activity", ndone, 0);
        run_mul(16'h0009, 16'h0009, p, ov, lat, occ);
        chk("after_rst_product", p, 32'h00000051);

        // Back-to-back: second Start issued in the first IDLE cycle
        run_mul(16'h0002, 16'h0003, p, ov, lat, occ);
        chk("b2b_first_product", p, 32'h00000006);
        chk("b2b_first_occ", occ, 17);
        run_mul(16'h0004, 16'h0005, p, ov, lat, occ);
        chk("b2b_second_product", p, 32'h00000014);
        chk("b2b_second_latency", lat, 16);
        chk("b2b_second_occ", occ, 17);

        // Randomized operands against plain multiplication
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'hFFFF;
            if (i == 1) rb = 16'h8001;
            exp_p = {16'h0, ra} * {16'h0, rb};
            run_mul(ra, rb, p, ov, lat, occ);
            chk($sformatf("rand%0d_product_%h_x_%h", i, ra, rb), p, exp_p);
            chk($sformatf("rand%0d_overflow", i), {31'h0, ov}, {31'h0, (exp_p[31:16] != 16'h0)});
            chk($sformatf("rand%0d_latency", i), lat, 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
